// File: rtl/resized_frame_capture.sv
// Captures a video stream into a linear frame buffer sized width_exp x height_exp.
// Each write lands at row_base + col; short or long lines and sync glitches raise sticky flags.
module resized_frame_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_data_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_H_SYNC,
    input  logic              in_V_SYNC,
    input  logic [10:0]       width_exp,
    input  logic [10:0]       height_exp,
    input  logic              clear_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_LINE = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [10:0]       r_row;
    logic [10:0]       r_col;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_vs_d;
    logic              r_hs_d;
    logic              r_de_d;

    logic              w_vs_rise;
    logic              w_hs_rise;
    logic              w_de_fall;
    logic              w_size_ok;
    logic [10:0]       w_row_inc;

    logic [1:0]        w_state_nx;
    logic [10:0]       w_row_nx;
    logic [10:0]       w_col_nx;
    logic [ADDR_W-1:0] w_base_nx;
    logic              w_wr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_lerr_set;
    logic              w_ferr_set;
    logic              w_done;

    assign w_vs_rise = in_V_SYNC & ~r_vs_d;
    assign w_hs_rise = in_H_SYNC & ~r_hs_d;
    assign w_de_fall = r_de_d & ~in_data_en;
    assign w_size_ok = (width_exp != 11'd0) && (height_exp != 11'd0);
    assign w_row_inc = r_row + 11'd1;

    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_base_nx  = r_row_base;
        w_wr       = 1'b0;
        w_wr_addr  = r_row_base + ADDR_W'(r_col);
        w_lerr_set = w_hs_rise & in_data_en;
        w_ferr_set = 1'b0;
        w_done     = 1'b0;

        if (!w_size_ok) begin
            w_state_nx = S_IDLE;
        end else if (w_vs_rise) begin
            // A frame sync always restarts at the top; a pixel on that cycle is row 0, col 0.
            w_ferr_set = (r_state == S_WAIT) || (r_state == S_LINE);
            w_row_nx   = 11'd0;
            w_base_nx  = '0;
            if (in_data_en) begin
                w_wr       = 1'b1;
                w_wr_addr  = '0;
                w_col_nx   = 11'd1;
                w_state_nx = S_LINE;
            end else begin
                w_col_nx   = 11'd0;
                w_state_nx = S_WAIT;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (in_data_en) begin
                        w_wr       = 1'b1;
                        w_wr_addr  = '0;
                        w_row_nx   = 11'd0;
                        w_base_nx  = '0;
                        w_col_nx   = 11'd1;
                        w_state_nx = S_LINE;
                    end
                end
                S_WAIT, S_LINE: begin
                    if (in_data_en) begin
                        w_state_nx = S_LINE;
                        if (r_col < width_exp) begin
                            w_wr     = 1'b1;
                            w_col_nx = r_col + 11'd1;
                        end else begin
                            w_lerr_set = 1'b1;
                        end
                    end else if (r_state == S_LINE && w_de_fall) begin
                        if (r_col != width_exp) begin
                            w_lerr_set = 1'b1;
                        end
                        w_base_nx = r_row_base + ADDR_W'(width_exp);
                        w_row_nx  = w_row_inc;
                        w_col_nx  = 11'd0;
                        if (w_row_inc == height_exp) begin
                            w_done     = 1'b1;
                            w_state_nx = S_DONE;
                        end else begin
                            w_state_nx = S_WAIT;
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_row      <= 11'd0;
            r_col      <= 11'd0;
            r_row_base <= '0;
            r_vs_d     <= 1'b0;
            r_hs_d     <= 1'b0;
            r_de_d     <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nx;
            r_row      <= w_row_nx;
            r_col      <= w_col_nx;
            r_row_base <= w_base_nx;
            r_vs_d     <= in_V_SYNC;
            r_hs_d     <= in_H_SYNC;
            r_de_d     <= in_data_en;
            wr_en      <= w_wr;
            if (w_wr) begin
                wr_addr <= w_wr_addr;
                wr_data <= data_in;
            end
            frame_done <= w_done;
            if (w_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // A new error event on the same cycle as clear_err keeps the flag set.
            if (w_lerr_set) begin
                line_err <= 1'b1;
            end else if (clear_err) begin
                line_err <= 1'b0;
            end
            if (w_ferr_set) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_resized_frame_capture.sv
// Directed bench for resized_frame_capture: expected writes are queued by the stimulus
// and popped by a negedge monitor; status flags are checked directly by the stimulus.
module tb_resized_frame_capture;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_data_en;
    logic [DATA_W-1:0] data_in;
    logic              in_H_SYNC;
    logic              in_V_SYNC;
    logic [10:0]       width_exp;
    logic [10:0]       height_exp;
    logic              clear_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              line_err;
    logic              frame_err;
    logic [7:0]        frame_cnt;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wr = 0;
    int   n_done = 0;
    int   last_addr = 0;

    resized_frame_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_en (in_data_en),
        .data_in    (data_in),
        .in_H_SYNC  (in_H_SYNC),
        .in_V_SYNC  (in_V_SYNC),
        .width_exp  (width_exp),
        .height_exp (height_exp),
        .clear_err  (clear_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every presented write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) n_done++;
            if (wr_en) begin
                n_wr++;
                last_addr = int'(wr_addr);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", int'(wr_addr), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), e.addr);
                    chk("wr_data", int'(wr_data), e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync();
        in_V_SYNC = 1'b1;
        tick();
        in_V_SYNC = 1'b0;
        tick();
    endtask

    task automatic pixel(input int d, input bit expect_wr, input int addr);
        in_data_en = 1'b1;
        data_in    = DATA_W'(d);
        if (expect_wr) exp_q.push_back('{addr: addr, data: d & 255});
        tick();
    endtask

    task automatic line_end();
        in_data_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic drive_line(input int n, input int d0, input int base, input int nwr);
        for (int i = 0; i < n; i++) pixel(d0 + i, i < nwr, base + i);
        line_end();
    endtask

    task automatic clear_flags();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    initial begin
        int d0;
        int w0;
        rst_n      = 1'b0;
        in_data_en = 1'b0;
        data_in    = '0;
        in_H_SYNC  = 1'b0;
        in_V_SYNC  = 1'b0;
        width_exp  = 11'd4;
        height_exp = 11'd2;
        clear_err  = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_errs", int'({line_err, frame_err, frame_done}), 0);
        rst_n = 1'b1;
        tick();

        // Basic 4x2 frame after V_SYNC
        vsync();
        drive_line(4, 8'h10, 0, 4);
        drive_line(4, 8'h14, 4, 4);
        chk("basic_done", n_done, 1);
        chk("basic_frame_cnt", int'(frame_cnt), 1);
        chk("basic_errs", int'({line_err, frame_err}), 0);

        // Capture starting from IDLE without V_SYNC, then a restart from DONE
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        drive_line(4, 8'h20, 0, 4);
        drive_line(4, 8'h24, 4, 4);
        chk("nosync_frame_cnt", int'(frame_cnt), 1);
        drive_line(4, 8'h30, 0, 4);
        drive_line(4, 8'h34, 4, 4);
        chk("restart_frame_cnt", int'(frame_cnt), 2);
        chk("nosync_errs", int'({line_err, frame_err}), 0);

        // Short line leaves a hole, third line starts at 8
        height_exp = 11'd3;
        vsync();
        drive_line(4, 8'h40, 0, 4);
        drive_line(3, 8'h44, 4, 3);
        chk("short_line_err", int'(line_err), 1);
        drive_line(4, 8'h50, 8, 4);
        chk("short_frame_cnt", int'(frame_cnt), 3);
        clear_flags();
        chk("clear_alone", int'(line_err), 0);

        // Long line: two pixels dropped
        vsync();
        drive_line(6, 8'h60, 0, 4);
        chk("long_line_err", int'(line_err), 1);
        drive_line(4, 8'h66, 4, 4);
        drive_line(4, 8'h6a, 8, 4);
        clear_flags();
        chk("long_cleared", int'(line_err), 0);

        // clear_err on the same cycle as a dropped pixel: set wins
        vsync();
        for (int i = 0; i < 4; i++) pixel(8'h70 + i, 1'b1, i);
        clear_err = 1'b1;
        pixel(8'h74, 1'b0, 0);
        clear_err = 1'b0;
        chk("clear_vs_set", int'(line_err), 1);
        line_end();
        drive_line(4, 8'h78, 4, 4);
        drive_line(4, 8'h7c, 8, 4);
        clear_flags();
        chk("clear_after", int'(line_err), 0);

        // V_SYNC mid-line restarts at address 0
        w0 = int'(frame_cnt);
        vsync();
        drive_line(4, 8'h80, 0, 4);
        pixel(8'h84, 1'b1, 4);
        pixel(8'h85, 1'b1, 5);
        in_V_SYNC = 1'b1;
        pixel(8'h90, 1'b1, 0);
        in_V_SYNC = 1'b0;
        for (int i = 1; i < 4; i++) pixel(8'h90 + i, 1'b1, i);
        line_end();
        chk("vs_frame_err", int'(frame_err), 1);
        chk("vs_cnt_hold", int'(frame_cnt), w0);
        chk("vs_line_ok", int'(line_err), 0);
        drive_line(4, 8'h94, 4, 4);
        drive_line(4, 8'h98, 8, 4);
        chk("vs_cnt_done", int'(frame_cnt), w0 + 1);
        clear_flags();
        chk("vs_cleared", int'(frame_err), 0);

        // H_SYNC rising while pixels are valid
        vsync();
        pixel(8'ha0, 1'b1, 0);
        in_H_SYNC = 1'b1;
        pixel(8'ha1, 1'b1, 1);
        in_H_SYNC = 1'b0;
        pixel(8'ha2, 1'b1, 2);
        pixel(8'ha3, 1'b1, 3);
        line_end();
        chk("hsync_line_err", int'(line_err), 1);
        drive_line(4, 8'ha4, 4, 4);
        drive_line(4, 8'ha8, 8, 4);
        clear_flags();

        // Zero width: nothing is captured
        w0 = n_wr;
        d0 = n_done;
        width_exp = 11'd0;
        vsync();
        drive_line(4, 8'hb0, 0, 0);
        chk("zero_w_writes", n_wr - w0, 0);
        chk("zero_w_done", n_done - d0, 0);
        width_exp = 11'd4;
        tick();

        // Asynchronous reset mid-frame
        vsync();
        pixel(8'hc0, 1'b1, 0);
        pixel(8'hc1, 1'b1, 1);
        in_data_en = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", int'(wr_en), 0);
        chk("arst_wr_addr", int'(wr_addr), 0);
        chk("arst_wr_data", int'(wr_data), 0);
        chk("arst_frame_cnt", int'(frame_cnt), 0);
        chk("arst_errs", int'({line_err, frame_err, frame_done}), 0);
        #3;
        rst_n = 1'b1;
        tick();

        // 1280x720: one-pixel lines, full last line reaches 921599
        width_exp  = 11'd1280;
        height_exp = 11'd720;
        d0 = n_done;
        vsync();
        for (int r = 0; r < 719; r++) drive_line(1, r, r * 1280, 1);
        drive_line(1280, 8'h5a, 719 * 1280, 1280);
        chk("big_last_addr", last_addr, 921599);
        chk("big_done", n_done - d0, 1);
        chk("big_frame_cnt", int'(frame_cnt), 1);

        // 1x1 frames: counter wraps 255 -> 0
        width_exp  = 11'd1;
        height_exp = 11'd1;
        for (int f = 0; f < 255; f++) drive_line(1, f, 0, 1);
        chk("wrap_frame_cnt", int'(frame_cnt), 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/resized_frame_capture.md
RESIZED_FRAME_CAPTURE -- requirements
Module: resized_frame_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width.
REQ-002 SHALL have parameter ADDR_W, default 20, frame-buffer address width (covers 1280x720).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data_en  input  1  pixel valid; a contiguous high run is one line.
REQ-006 SHALL have port data_in  input  DATA_W  pixel value.
REQ-007 SHALL have port in_H_SYNC  input  1  line sync; monitored only.
REQ-008 SHALL have port in_V_SYNC  input  1  frame sync; rising edge marks frame start.
REQ-009 SHALL have ports width_exp, height_exp  input  11 each  expected output frame size; static during a frame.
REQ-010 SHALL have port clear_err  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have ports wr_en 1, wr_addr ADDR_W, wr_data DATA_W  output  buffer write.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.
REQ-013 SHALL have ports line_err, frame_err  output  1 each  sticky error flags.
REQ-014 SHALL have port frame_cnt  output  8  completed frames, wraps 255->0.

Function
REQ-015 SHALL implement states IDLE, WAIT_LINE, LINE, DONE.
REQ-016 SHALL register previous in_V_SYNC, in_H_SYNC and in_data_en for edge detection.
REQ-017 IDLE or DONE: V_SYNC rising edge -> WAIT_LINE with row=0, col=0, row_base=0.
REQ-018 IDLE or DONE: in_data_en=1 without a V_SYNC edge -> LINE, and that pixel SHALL be written at address 0.
REQ-019 WAIT_LINE: in_data_en=1 -> LINE, and the pixel SHALL be accepted.
REQ-020 LINE: each in_data_en=1 cycle with col < width_exp SHALL write data_in to row_base+col, then increment col.
REQ-021 LINE: pixels with col >= width_exp SHALL be dropped (no wr_en) and SHALL set line_err.
REQ-022 LINE: in_data_en falling edge ends the line; col != width_exp SHALL set line_err; row_base += width_exp, row += 1, col = 0.
REQ-023 At line end with new row == height_exp: frame_done pulses 1 cycle, frame_cnt += 1, state -> DONE.
REQ-024 Otherwise line end SHALL go to WAIT_LINE.
REQ-025 A short line SHALL leave unwritten addresses; the next line SHALL start at the new row_base.
REQ-026 V_SYNC rising edge in WAIT_LINE or LINE SHALL set frame_err and restart the frame per REQ-017; a pixel on that cycle SHALL be written at address 0.
REQ-027 in_H_SYNC rising edge while in_data_en=1 SHALL set line_err.
REQ-028 wr_en, wr_addr and wr_data SHALL be registered, exactly 1 cycle after the sampled pixel; wr_addr, wr_data hold when wr_en=0.
REQ-029 Address arithmetic SHALL be ADDR_W-bit incremental adds with no multiplier; overflow wraps silently.
REQ-030 clear_err=1 SHALL clear line_err and frame_err next cycle; a set event on the same cycle SHALL win.
REQ-031 width_exp=0 or height_exp=0: no writes, no frame_done, state SHALL stay IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE and zero wr_en, wr_addr, wr_data, frame_done, line_err, frame_err, frame_cnt, row, col, row_base and edge registers.
REQ-033 Reset mid-line SHALL abandon the frame; after release, capture SHALL restart only per REQ-017/018.

Verification
REQ-034 width_exp=4, height_exp=2, V_SYNC pulse, two 4-pixel lines 0x10..0x17 -> wr_addr 0..7 with matching data, frame_done once, frame_cnt=1, no errors.
REQ-035 Same size, no V_SYNC, data starts in IDLE -> first write at addr 0, frame completes normally, then the next run after DONE restarts at addr 0.
REQ-036 Second line 3 pixels -> writes 4,5,6, line_err=1, third line starts at addr 8; 6-pixel line -> 2 pixels dropped, line_err=1.
REQ-037 V_SYNC rising mid-line 1 -> frame_err=1, next pixel at addr 0, frame_cnt unchanged until completion.
REQ-038 clear_err together with a new line error -> line_err stays 1; clear_err alone -> 0 next cycle.
REQ-039 rst_n low mid-frame -> all outputs 0 immediately; 1280x720 frame after release -> last wr_addr 921599, frame_done once.
